fma16_operand_unpack: RTL and testbench
=======================================

Name: fma16_operand_unpack

Overview:
- Front-end for the fma16 datapath. Accepts raw half-precision operands x, y, z and the op select (mul, add) over a valid/ready handshake.
- Applies op substitution, splits each operand into sign/exponent/significand and decodes the class flags (zero, inf, NaN, normal) that the result-selection logic consumes.
- Delivers the decoded bundle downstream over a valid/ready handshake. A 2-entry skid buffer gives full throughput with a registered in_ready.

Parameters:
- QNAN, 16'h7E00, canonical quiet NaN forwarded on nan_out when any input is NaN
- ONE, 16'h3C00, value substituted for y when mul=0

Ports:
- clk  input  1  clock, all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream bundle valid
- in_ready  output  1  block can accept (registered)
- x, y, z  input  16 each  raw binary16 operands
- mul, add  input  1 each  op select
- out_valid  output  1  decoded bundle valid
- out_ready  input  1  downstream accepts
- xs, ys, zs  output  1 each  operand signs after substitution
- xe, ye, ze  output  5 each  biased exponents (effective, see Behaviour)
- xm, ym, zm  output  11 each  significand with hidden bit
- xZero, yZero, zZero, xInf, yInf, zInf, xNan, yNan, zNan, xNormal, yNormal, zNormal  output  1 each  class flags
- anySnan  output  1  any operand is a signalling NaN (exp=31, frac!=0, frac[9]=0)
- nan_out  output  16  QNAN
- mul_q, add_q  output  1 each  registered op select
- x_q  output  16  raw x, used for the no-op passthrough

Behaviour:
- Reset (async assert, sync deassert to clk): both skid entries empty; out_valid=0; in_ready=1; all data outputs 0.
- Substitution, applied before decode:
  - mul=0: y is replaced by ONE.
  - add=0: z is replaced by 16'h8000 (-0), so the product sign is preserved.
  - mul=add=0: no substitution; bundle still flows so x_q can pass through.
- Decode per operand, with e = bits[14:10] and f = bits[9:0]:
  - zero: e=0, f=0
  - inf: e=31, f=0
  - NaN: e=31, f!=0
  - normal: 1<=e<=30; then m = {1, f} and exponent = e
  - subnormal: handled per the optional feature.
  - Exactly one of Zero/Inf/Nan/Normal is set per operand, except a subnormal with FMA16_SUBNORM_EN defined, which has all four clear.
- Handshake:
  - Input transfer on in_valid & in_ready; output transfer on out_valid & out_ready.
  - Latency is 1 cycle: a bundle accepted at edge N appears on the outputs after edge N.
  - Outputs are held stable while out_valid & !out_ready.
- Skid buffer: a main register plus one skid register.
  - in_ready = skid register empty.
  - Accept while main is full and stalled: the bundle goes to skid and in_ready drops on the next cycle.
  - Main drains while skid is full: skid moves to main and in_ready rises.
  - Simultaneous accept and drain with skid empty: main is loaded with the new bundle and occupancy is unchanged.
  - Sustained in_valid=out_ready=1 gives one bundle per cycle.
- Full-stall boundary: both entries full and out_ready=0 gives in_ready=0; upstream data is ignored until a drain.
- Bundles leave in strict FIFO order; none are dropped or duplicated.
- reset_n assertion mid-stream discards all held bundles immediately (out_valid drops asynchronously).

Optional Feature:
- Macro: FMA16_SUBNORM_EN
- Defined: a subnormal (e=0, f!=0) decodes with exponent=1, m={0, f}, and all class flags clear.
- Undefined: flush-to-zero.
  - Subnormal decodes as Zero=1 with m=0 and exponent=0; sign is kept.
  - The substituted and passed-through raw x_q is unchanged.

Test Plan:
- Reset release, then in_valid=1 with x=16'h3C00, y=16'h4000, z=16'h0000, mul=add=1 -> one cycle later out_valid=1, xe=15, xm=11'h400, ye=16, zZero=1, xNormal=yNormal=1.
- mul=0, add=1, y=16'h7C00 -> ys=0, ye=15, ym=11'h400, yInf=0, yNormal=1 (y substituted with ONE).
- x=16'h7C01, z=16'hFC00 -> xNan=1, anySnan=1, zInf=1, zs=1, nan_out=16'h7E00.
- Hold out_ready=0 and offer 3 back-to-back bundles A, B, C -> A held on outputs, B in skid, in_ready=0, C is not accepted; then out_ready=1 -> A, then B, then C (once accepted), in order, with no loss.
- x=16'h0001 -> with FMA16_SUBNORM_EN: xe=1, xm=11'h001, all x flags 0; without: xZero=1, xm=0.
- Assert reset_n low while both entries are full -> out_valid=0 and in_ready=1 immediately, and after release no stale bundle appears.

Source files
------------

// File: rtl/fma16_operand_unpack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fma16_operand_unpack: op substitution + binary16 class decode behind a   |
// | 2-entry skid buffer. FMA16_SUBNORM_EN keeps subnormals (else flush).     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fma16_operand_unpack #(
  parameter logic [15:0] QNAN = 16'h7E00,
  parameter logic [15:0] ONE  = 16'h3C00
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] z,
  input  logic        mul,
  input  logic        add,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        xs,
  output logic        ys,
  output logic        zs,
  output logic [4:0]  xe,
  output logic [4:0]  ye,
  output logic [4:0]  ze,
  output logic [10:0] xm,
  output logic [10:0] ym,
  output logic [10:0] zm,
  output logic        xZero,
  output logic        yZero,
  output logic        zZero,
  output logic        xInf,
  output logic        yInf,
  output logic        zInf,
  output logic        xNan,
  output logic        yNan,
  output logic        zNan,
  output logic        xNormal,
  output logic        yNormal,
  output logic        zNormal,
  output logic        anySnan,
  output logic [15:0] nan_out,
  output logic        mul_q,
  output logic        add_q,
  output logic [15:0] x_q
);

  typedef struct packed {
    logic        s;
    logic [4:0]  e;
    logic [10:0] m;
    logic        zero;
    logic        inf;
    logic        nan;
    logic        normal;
  } op_t;

  typedef struct packed {
    op_t         ox;
    op_t         oy;
    op_t         oz;
    logic        snan;
    logic [15:0] nan_val;
    logic        mul;
    logic        add;
    logic [15:0] raw_x;
  } bundle_t;

  function automatic op_t decode(input logic [15:0] v);
    op_t d;
    d   = '0;
    d.s = v[15];
    if (v[14:10] == 5'd0) begin
      if (v[9:0] == 10'd0) begin
        d.zero = 1'b1;
      end else begin
`ifdef FMA16_SUBNORM_EN
        d.e = 5'd1;
        d.m = {1'b0, v[9:0]};
`else
        d.zero = 1'b1;
`endif
      end
    end else begin
      // Hidden bit follows a nonzero exponent, including inf/NaN encodings.
      d.e = v[14:10];
      d.m = {1'b1, v[9:0]};
      if (v[14:10] == 5'd31) begin
        d.inf = (v[9:0] == 10'd0);
        d.nan = (v[9:0] != 10'd0);
      end else begin
        d.normal = 1'b1;
      end
    end
    return d;
  endfunction

  function automatic logic is_snan(input logic [15:0] v);
    return (&v[14:10]) && (|v[9:0]) && !v[9];
  endfunction

  logic [15:0] y_eff;
  logic [15:0] z_eff;
  bundle_t     in_bundle;
  bundle_t     main_q, skid_q, main_d, skid_d;
  logic        main_valid, skid_valid, mv_d, sv_d;
  logic        in_ready_q;
  logic        accept, drain;

  always_comb begin
    y_eff             = mul ? y : ONE;
    z_eff             = add ? z : 16'h8000;
    in_bundle.ox      = decode(x);
    in_bundle.oy      = decode(y_eff);
    in_bundle.oz      = decode(z_eff);
    in_bundle.snan    = is_snan(x) | is_snan(y_eff) | is_snan(z_eff);
    in_bundle.nan_val = (in_bundle.ox.nan | in_bundle.oy.nan | in_bundle.oz.nan) ? QNAN : 16'h0000;
    in_bundle.mul     = mul;
    in_bundle.add     = add;
    in_bundle.raw_x   = x;
  end

  // Skid is only ever filled while main is stalled, so it always holds the younger bundle.
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    mv_d   = main_valid;
    sv_d   = skid_valid;
    accept = in_valid & in_ready_q;
    drain  = main_valid & out_ready;
    if (drain) begin
      if (skid_valid) begin
        main_d = skid_q;
        sv_d   = 1'b0;
      end else begin
        mv_d = accept;
        if (accept) main_d = in_bundle;
      end
    end else if (accept) begin
      if (!main_valid) begin
        main_d = in_bundle;
        mv_d   = 1'b1;
      end else begin
        skid_d = in_bundle;
        sv_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_valid <= mv_d;
      skid_valid <= sv_d;
      in_ready_q <= !sv_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid;
  assign xs        = main_q.ox.s;
  assign ys        = main_q.oy.s;
  assign zs        = main_q.oz.s;
  assign xe        = main_q.ox.e;
  assign ye        = main_q.oy.e;
  assign ze        = main_q.oz.e;
  assign xm        = main_q.ox.m;
  assign ym        = main_q.oy.m;
  assign zm        = main_q.oz.m;
  assign xZero     = main_q.ox.zero;
  assign yZero     = main_q.oy.zero;
  assign zZero     = main_q.oz.zero;
  assign xInf      = main_q.ox.inf;
  assign yInf      = main_q.oy.inf;
  assign zInf      = main_q.oz.inf;
  assign xNan      = main_q.ox.nan;
  assign yNan      = main_q.oy.nan;
  assign zNan      = main_q.oz.nan;
  assign xNormal   = main_q.ox.normal;
  assign yNormal   = main_q.oy.normal;
  assign zNormal   = main_q.oz.normal;
  assign anySnan   = main_q.snan;
  assign nan_out   = main_q.nan_val;
  assign mul_q     = main_q.mul;
  assign add_q     = main_q.add;
  assign x_q       = main_q.raw_x;

endmodule
`default_nettype wire

// File: tb/tb_fma16_operand_unpack.sv
`default_nettype none
// Scoreboard bench for fma16_operand_unpack: directed test-plan bundles, stall,
// mid-stream reset, then randomized traffic against a value-level reference model.
module tb_fma16_operand_unpack;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] x = '0, y = '0, z = '0;
  logic        mul = 1'b0, add = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        xs, ys, zs;
  logic [4:0]  xe, ye, ze;
  logic [10:0] xm, ym, zm;
  logic        xZero, yZero, zZero, xInf, yInf, zInf, xNan, yNan, zNan;
  logic        xNormal, yNormal, zNormal, anySnan, mul_q, add_q;
  logic [15:0] nan_out, x_q;

  fma16_operand_unpack dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .z(z), .mul(mul), .add(add),
    .out_valid(out_valid), .out_ready(out_ready),
    .xs(xs), .ys(ys), .zs(zs), .xe(xe), .ye(ye), .ze(ze), .xm(xm), .ym(ym), .zm(zm),
    .xZero(xZero), .yZero(yZero), .zZero(zZero), .xInf(xInf), .yInf(yInf), .zInf(zInf),
    .xNan(xNan), .yNan(yNan), .zNan(zNan),
    .xNormal(xNormal), .yNormal(yNormal), .zNormal(zNormal),
    .anySnan(anySnan), .nan_out(nan_out), .mul_q(mul_q), .add_q(add_q), .x_q(x_q)
  );

  always #5 clk = ~clk;

  localparam int W = 98;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] act;
  logic         held = 1'b0;
  logic [W-1:0] held_val;

  assign act = {xs, xe, xm, xZero, xInf, xNan, xNormal,
                ys, ye, ym, yZero, yInf, yNan, yNormal,
                zs, ze, zm, zZero, zInf, zNan, zNormal,
                anySnan, nan_out, mul_q, add_q, x_q};

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Reference: classify each operand from its numeric fields.
  function automatic logic [20:0] ref_op(input int v, output bit nan, output bit snan);
    int  ex, fr, e, m;
    bit  s, zero, inf, normal;
    s = (v >= 32768); ex = (v / 1024) % 32; fr = v % 1024;
    zero = 0; inf = 0; nan = 0; normal = 0; e = 0; m = 0;
    if (ex == 0 && fr == 0) zero = 1;
    else if (ex == 0) begin
`ifdef FMA16_SUBNORM_EN
      e = 1; m = fr;
`else
      zero = 1;
`endif
    end else begin
      e = ex; m = 1024 + fr;
      if (ex < 31) normal = 1;
      else if (fr == 0) inf = 1;
      else nan = 1;
    end
    snan = nan && (fr < 512);
    return {s, e[4:0], m[10:0], zero, inf, nan, normal};
  endfunction

  function automatic logic [W-1:0] model(input int vx, input int vy, input int vz,
                                         input bit m, input bit a);
    logic [20:0] ox, oy, oz;
    bit nx, ny, nz, sx, sy, sz;
    logic [15:0] no, rx;
    if (!m) vy = 16'h3C00;
    if (!a) vz = 16'h8000;
    ox = ref_op(vx, nx, sx);
    oy = ref_op(vy, ny, sy);
    oz = ref_op(vz, nz, sz);
    no = (nx || ny || nz) ? 16'h7E00 : 16'h0000;
    rx = vx[15:0];
    return {ox, oy, oz, (sx || sy || sz), no, m, a, rx};
  endfunction

  function automatic logic [15:0] rnd16();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom % 5)
      0: r[14:10] = 5'd0;
      1: r[14:10] = 5'd31;
      2: r[9:0]   = 10'd0;
      default: ;
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    if (out_valid && held) chk("hold_stable", act, held_val);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_out: got %h want none", act);
      end else begin
        chk("bundle", act, exp_q.pop_front());
      end
    end
    held     = out_valid && !out_ready;
    held_val = act;
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                      input logic m, input logic ad);
    bit done = 0;
    @(posedge clk); #1;
    in_valid = 1; x = a; y = b; z = c; mul = m; add = ad;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(a, b, c, m, ad));
        done = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 0;
    if (!done) begin n_cmp++; n_err++; $display("FAIL send_timeout: got 0 want 1"); end
  endtask

  task automatic drain_all(input string name);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    chk(name, W'(exp_q.size()), '0);
  endtask

  initial begin
    int acc = 0;
    #12;
    chk("reset_out_valid", W'(out_valid), W'(0));
    chk("reset_in_ready", W'(in_ready), W'(1));
    chk("reset_data", act, '0);
    @(posedge clk); #1 reset_n = 1;

    out_ready = 1;
    send(16'h3C00, 16'h4000, 16'h0000, 1, 1);
    send(16'h1234, 16'h7C00, 16'h3800, 0, 1);
    send(16'h7C01, 16'h4000, 16'hFC00, 1, 1);
    send(16'h0001, 16'h8001, 16'h7E00, 1, 1);
    send(16'hABCD, 16'h7D00, 16'h7C00, 0, 0);
    drain_all("drain_directed");

    // Stall: A in main, B in skid, C refused until drain.
    out_ready = 0;
    send(16'h3C00, 16'h3C01, 16'h3C02, 1, 1);
    send(16'h4000, 16'h4001, 16'h4002, 1, 1);
    in_valid = 1; x = 16'h4400; y = 16'h4401; z = 16'h4402; mul = 1; add = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", W'(in_ready), W'(0));
      chk("stall_valid", W'(out_valid), W'(1));
    end
    @(posedge clk); #1 out_ready = 1;
    begin
      bit done = 0;
      for (int i = 0; i < 20 && !done; i++) begin
        @(negedge clk);
        if (in_ready) begin exp_q.push_back(model(16'h4400, 16'h4401, 16'h4402, 1, 1)); done = 1; end
        @(posedge clk); #1;
      end
      in_valid = 0;
      chk("stall_c_accepted", W'(done), W'(1));
    end
    drain_all("drain_stall");

    // Asynchronous reset with both entries occupied.
    out_ready = 0;
    send(16'h5000, 16'h5001, 16'h5002, 1, 1);
    send(16'h6000, 16'h6001, 16'h6002, 1, 0);
    @(posedge clk); #3 reset_n = 0;
    #1;
    chk("async_rst_valid", W'(out_valid), W'(0));
    chk("async_rst_ready", W'(in_ready), W'(1));
    exp_q.delete();
    @(posedge clk); #1 reset_n = 1; out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_stale", W'(out_valid), W'(0));
    end

    // Randomized traffic.
    for (int g = 0; g < 5000 && acc < 300; g++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      x = rnd16(); y = rnd16(); z = rnd16();
      mul = 1'($urandom); add = 1'($urandom);
      @(negedge clk);
      if (in_valid && in_ready) begin
        exp_q.push_back(model(x, y, z, mul, add));
        acc++;
      end
    end
    @(posedge clk); #1 in_valid = 0; out_ready = 1;
    chk("random_accepted", W'(acc), W'(300));
    drain_all("drain_random");
    @(negedge clk);
    chk("final_idle", W'(out_valid), W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
